// File: rtl/mul_issue_sched_pkg.sv
`default_nettype none
// ============================================================
// mul_sched_pkg : shared constants and state type for the multiplier scheduler
// Rev 1.0
// ============================================================
package mul_sched_pkg;

    localparam int LANES   = 4;
    localparam int MUL_LAT = 4;
    localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mul_issue_sched_if.sv
`default_nettype none
// ============================================================
// mul_issue_sched_if : lane request / result bus of the multiplier scheduler
// Rev 1.0
// ============================================================
interface mul_issue_sched_if #(
    parameter int LANES = mul_sched_pkg::LANES
);
    localparam int c_lane_w = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LANES-1:0]        req;
    logic [LANES-1:0][31:0]  srca;
    logic [LANES-1:0][31:0]  srcb;
    logic [LANES-1:0][4:0]   dst;
    logic                    flush;
    logic [LANES-1:0]        stall;
    logic                    res_valid;
    logic [c_lane_w-1:0]     res_lane;
    logic [4:0]              res_dst;
    logic [31:0]             res_data;
    logic                    busy;

    modport master (
        output req, srca, srcb, dst, flush,
        input  stall, res_valid, res_lane, res_dst, res_data, busy
    );

    modport slave (
        input  req, srca, srcb, dst, flush,
        output stall, res_valid, res_lane, res_dst, res_data, busy
    );

endinterface
`default_nettype wire

// File: rtl/mul_issue_sched_rr_pick.sv
`default_nettype none
// ============================================================
// rr_pick : combinational round-robin lane picker starting at i_rr_ptr
// Rev 1.0
// ============================================================
module rr_pick #(
    parameter int LANES  = 4,
    parameter int LANE_W = 2
) (
    input  wire logic [LANES-1:0]  i_req,
    input  wire logic [LANE_W-1:0] i_rr_ptr,
    output logic [LANES-1:0]       o_gnt,
    output logic [LANE_W-1:0]      o_gnt_idx,
    output logic                   o_any
);

    always_comb begin
        int w_sum;
        logic [LANE_W-1:0] w_idx;
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_any     = 1'b0;
        w_sum     = 0;
        w_idx     = '0;
        for (int i = 0; i < LANES; i++) begin
            w_sum = (int'(i_rr_ptr) + i) % LANES;
            w_idx = LANE_W'(w_sum);
            if (!o_any && i_req[w_idx]) begin
                o_any        = 1'b1;
                o_gnt[w_idx] = 1'b1;
                o_gnt_idx    = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mul_issue_sched.sv
`default_nettype none
// ============================================================
// mul_issue_sched : round-robin issue of lane multiplies onto one shared multiplier
// Rev 1.0
// ============================================================
module mul_issue_sched #(
    parameter int LANES   = mul_sched_pkg::LANES,
    parameter int MUL_LAT = mul_sched_pkg::MUL_LAT
) (
    input  wire logic         clk,
    input  wire logic         reset,
    mul_issue_sched_if.slave  bus
);
    import mul_sched_pkg::*;

    localparam int c_lane_w = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int c_cnt_w  = $clog2(MUL_LAT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(MUL_LAT - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_lane_w-1:0] r_rr_ptr;
    logic [c_lane_w-1:0] r_lane;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [31:0]         r_srca;
    logic [31:0]         r_srcb;
    logic [4:0]          r_dst;

    logic [LANES-1:0]    w_gnt;
    logic [c_lane_w-1:0] w_gnt_idx;
    logic                w_any;
    logic                w_grant;
    logic [31:0]         w_sel_a;
    logic [31:0]         w_sel_b;
    logic [4:0]          w_sel_dst;
    logic [31:0]         w_prod;
    logic                w_res_valid;
    logic [LANES-1:0]    w_stall_mask;

    rr_pick #(
        .LANES  (LANES),
        .LANE_W (c_lane_w)
    ) u_rr_pick (
        .i_req     (bus.req),
        .i_rr_ptr  (r_rr_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_any     (w_any)
    );

    always_comb begin
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_sel_dst = '0;
        for (int i = 0; i < LANES; i++) begin
            w_sel_a   |= bus.srca[i] & {32{w_gnt[i]}};
            w_sel_b   |= bus.srcb[i] & {32{w_gnt[i]}};
            w_sel_dst |= bus.dst[i]  & {5{w_gnt[i]}};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!bus.flush && w_any) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN:  if (r_cnt == '0) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (bus.flush) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
            r_srca   <= '0;
            r_srcb   <= '0;
            r_dst    <= '0;
            r_lane   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_srca   <= w_sel_a;
                r_srcb   <= w_sel_b;
                r_dst    <= w_sel_dst;
                r_lane   <= w_gnt_idx;
                r_cnt    <= c_cnt_load;
                r_rr_ptr <= (w_gnt_idx == c_lane_w'(LANES - 1)) ? '0 : w_gnt_idx + 1'b1;
            end else if (r_state == ST_RUN && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Low 32 bits of a two's-complement product do not depend on operand signedness.
    assign w_prod = r_srca * r_srcb;

    assign w_res_valid = (r_state == ST_DONE) && !bus.flush;

    always_comb begin
        w_stall_mask = '0;
        if (w_res_valid) w_stall_mask[r_lane] = 1'b1;
    end

    assign bus.stall     = bus.req & ~w_stall_mask;
    assign bus.res_valid = w_res_valid;
    assign bus.res_lane  = w_res_valid ? r_lane : '0;
    assign bus.res_dst   = w_res_valid ? r_dst  : '0;
    assign bus.res_data  = w_res_valid ? w_prod : '0;
    assign bus.busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/mul_issue_sched.md
MUL_ISSUE_SCHED -- requirements
Module: mul_issue_sched

Interface
REQ-001 Parameter LANES, default 4, number of issue lanes sharing the multiplier.
REQ-002 Parameter MUL_LAT, default 4, cycles spent in RUN per multiply (>=1).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  LANES  per-lane multiply request (lane's ismultiply and valid), held until released.
REQ-006 srca  input  LANES x 32  per-lane operand A, valid while req is high.
REQ-007 srcb  input  LANES x 32  per-lane operand B, valid while req is high.
REQ-008 dst  input  LANES x 5  per-lane destination register.
REQ-009 flush  input  1  synchronous pipeline flush; aborts the in-flight multiply.
REQ-010 stall  output  LANES  combinational per-lane hold.
REQ-011 res_valid  output  1  one-cycle result strobe.
REQ-012 res_lane  output  clog2(LANES)  lane owning the result.
REQ-013 res_dst  output  5  destination register of the result.
REQ-014 res_data  output  32  low 32 bits of the signed product.
REQ-015 busy  output  1  high when state is not IDLE.

Function
REQ-016 FSM states IDLE, RUN, DONE.
REQ-017 IDLE: if flush is low and any req is high, grant one lane, latch its srca, srcb, dst and lane index, load cnt=MUL_LAT-1, and go to RUN; otherwise stay in IDLE.
REQ-018 Grant is round-robin: search starts at rr_ptr and wraps modulo LANES; on grant, rr_ptr becomes granted+1 mod LANES (LANES-1 wraps to 0).
REQ-019 RUN: decrement cnt each cycle; when cnt==0, go to DONE, so RUN lasts exactly MUL_LAT cycles.
REQ-020 DONE: res_valid=1 for exactly one cycle with the latched res_lane, res_dst and res_data; the next state is IDLE.
REQ-021 res_data = low 32 bits of signed(srca) x signed(srcb), computed from the latched operands; later operand changes have no effect.
REQ-022 stall[i] = req[i], except stall[i]=0 in DONE when i==res_lane; every requesting lane stalls until its own result strobe.
REQ-023 First req seen in IDLE at cycle 0 gives res_valid in cycle MUL_LAT+1.
REQ-024 Only one multiply is in flight at a time; requests arriving in RUN or DONE wait for IDLE.
REQ-025 flush high in any state forces the next state to IDLE, suppresses grant and res_valid that cycle, and leaves rr_ptr unchanged.
REQ-026 res_valid, res_lane, res_dst and res_data hold 0 outside DONE.
REQ-027 If req of the owning lane drops during RUN, the multiply completes and still strobes res_valid; the pipeline discards it.

Reset
REQ-028 Reset forces state=IDLE, rr_ptr=0, cnt=0, and clears all latched operands, dst and lane.
REQ-029 During reset, res_valid=0, busy=0, res_* = 0, and stall=req.
REQ-030 Reset asserted mid-RUN aborts the operation with no result strobe after release.

Structure
REQ-031 Package mul_sched_pkg holds LANES, MUL_LAT, the state enum type and the lane-index width.
REQ-032 Sub-module rr_pick is combinational: inputs req and rr_ptr; outputs a one-hot grant, a grant index and any-valid.
REQ-033 The product is computed in mul_issue_sched from latched operands; no other sub-modules.

Verification
REQ-034 Single request: req=0001, srca=7, srcb=-3 -> res_valid in cycle 5 with res_lane=0, res_data=0xFFFFFFEB; stall[0]=1 in cycles 0-4 and 0 in cycle 5.
REQ-035 Contention: req=1111 held, rr_ptr=0 -> grant order 0,1,2,3,0; each result 6 cycles apart; non-served lanes stall throughout.
REQ-036 Wrap: rr_ptr=3, req=1001 -> lane 3 is served first, then lane 0.
REQ-037 Flush in the 2nd RUN cycle -> IDLE next cycle, no res_valid, rr_ptr unchanged, the pending lane is re-granted.
REQ-038 Async reset pulse mid-RUN -> all outputs are 0 immediately (stall=req), and a fresh request afterwards starts from lane 0.
REQ-039 Overflow: srca=0x80000000, srcb=2 -> res_data=0x00000000; srca=0x10000, srcb=0x10000 -> res_data=0x00000000.
